// File: rtl/mat3_seq_mult.sv
// Sequential 3x3 unsigned matrix multiplier C = A x B sharing one MAC unit.
// 27 MAC steps per job, valid/ready handshake on both sides.
module mat3_seq_mult #(
  parameter int unsigned DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [9*DW-1:0] mat_in_a,
  input  logic [9*DW-1:0] mat_in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [9*DW-1:0] mat_out,
  output logic            ovf,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_q, state_d;

  logic [DW-1:0]     a_q [9];
  logic [DW-1:0]     b_q [9];
  logic [DW-1:0]     c_q [9];
  logic              ovf_q;
  logic [2*DW+1:0]   acc_q;
  logic [2*DW+1:0]   acc_next;
  logic [2*DW-1:0]   prod;
  logic [1:0]        i_q, j_q, k_q;
  logic [3:0]        a_idx, b_idx, c_idx;
  logic              last_step;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    last_step = (i_q == 2'd2) && (j_q == 2'd2) && (k_q == 2'd2);
    case (state_q)
      IDLE:    if (in_valid)  state_d = CALC;
      CALC:    if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == DONE);
  assign ovf       = ovf_q;

  // Shared MAC: A[i][k] * B[k][j] at full precision.
  always_comb begin
    a_idx    = {2'b00, i_q} * 4'd3 + {2'b00, k_q};
    b_idx    = {2'b00, k_q} * 4'd3 + {2'b00, j_q};
    c_idx    = {2'b00, i_q} * 4'd3 + {2'b00, j_q};
    prod     = {{DW{1'b0}}, a_q[a_idx]} * {{DW{1'b0}}, b_q[b_idx]};
    acc_next = acc_q + {2'b00, prod};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '{default: '0};
      b_q   <= '{default: '0};
      c_q   <= '{default: '0};
      ovf_q <= 1'b0;
      acc_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          for (int unsigned n = 0; n < 9; n++) begin
            a_q[n] <= mat_in_a[(8-n)*DW +: DW];
            b_q[n] <= mat_in_b[(8-n)*DW +: DW];
          end
          c_q   <= '{default: '0};
          ovf_q <= 1'b0;
          acc_q <= '0;
          i_q   <= '0;
          j_q   <= '0;
          k_q   <= '0;
        end
        CALC: begin
          if (k_q == 2'd2) begin
            c_q[c_idx] <= acc_next[DW-1:0];
            ovf_q      <= ovf_q | (acc_next[2*DW+1:DW] != '0);
            acc_q      <= '0;
            k_q        <= '0;
            if (j_q == 2'd2) begin
              j_q <= '0;
              i_q <= (i_q == 2'd2) ? 2'd0 : i_q + 2'd1;
            end else begin
              j_q <= j_q + 2'd1;
            end
          end else begin
            acc_q <= acc_next;
            k_q   <= k_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mat_out = '0;
    for (int unsigned n = 0; n < 9; n++)
      mat_out[(8-n)*DW +: DW] = c_q[n];
  end

endmodule

// File: doc/mat3_seq_mult.md
Name: mat3_seq_mult

Overview:
- Sequential 3x3 matrix multiplier C = A x B for packed 8-bit elements, built on a single shared multiply-accumulate unit.
- Scheduler walks i, j, k over 27 MAC steps: one product per cycle, one output element every 3 cycles.
- Area-reduced, handshaked replacement for the combinational mat3mult in the matrix path.
- Bus format and results are bit-identical to mat3mult: row-major, element [0][0] in the MSBs, results truncated to DW bits.

Parameters:
- DW, 8, element width in bits. Matrix dimension is fixed at 3.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- mat_in_a  in  9*DW  matrix A, row-major; element [r][c] at bits [(9-(3r+c))*DW-1 -: DW].
- mat_in_b  in  9*DW  matrix B, same packing as A.
- out_valid  out  1  mat_out holds a complete result.
- out_ready  in  1  consumer accepts the result.
- mat_out  out  9*DW  result C, same packing as A.
- ovf  out  1  at least one full-precision element of C exceeded 2^DW-1; valid with out_valid.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high, on port rst.
  - Reset wins over all other inputs, including mid-CALC and mid-DONE.
  - Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, ovf=0, mat_out=0, counters and accumulator=0.
- States:
  - IDLE: in_ready=1. On in_valid=1 at a rising edge, latch A and B, clear mat_out, ovf, accumulator and i/j/k, then go to CALC. Later changes to mat_in_a/b have no effect.
  - CALC: in_ready=0. Each cycle computes acc_next = acc + A[i][k]*B[k][j] at full precision: 2*DW-bit product, 2*DW+2-bit accumulator.
    - When k<2: acc <= acc_next; k <= k+1.
    - When k==2: C[i][j] <= acc_next[DW-1:0]; ovf <= ovf | (acc_next > 2^DW-1); acc <= 0; k <= 0; advance j, and when j wraps 2->0 advance i.
    - Order is row-major: C[0][0], C[0][1], ..., C[2][2].
    - After the 27th step (i=j=k=2), go to DONE.
  - DONE: out_valid=1; mat_out and ovf held stable. On out_ready=1 at a rising edge, go to IDLE. in_ready is high from the following cycle; there is no same-cycle re-accept.
- Timing:
  - out_valid rises exactly 27 cycles after the accepting edge.
  - Throughput is one job per 29 cycles with out_ready tied high.
- Outputs during CALC:
  - mat_out shows partial results: completed elements hold their final value, the rest read 0.
  - Consumers must qualify mat_out with out_valid.
- Handshake rules:
  - in_valid is ignored outside IDLE; no queuing.
  - out_ready is ignored outside DONE.
  - out_valid never drops without an out_ready handshake, except on rst.
- Arithmetic:
  - Unsigned. Element result is the low DW bits of the exact sum, matching mat3mult.
  - Maximum exact sum is 3*(2^DW-1)^2, which fits in 2*DW+2 bits; the accumulator never wraps.

Test Plan:
- Reset then basic job:
  - Stimulus: rst for 2 cycles, then A={00,01,02,03,04,05,06,07,08}, B={01,06,07,02,05,08,03,04,09}, in_valid one cycle, out_ready=1.
  - Response: out_valid exactly 27 cycles after accept; mat_out={08,0D,1A,1A,3A,62,2C,67,AA}; ovf=0.
- Overflow:
  - Stimulus: A and B all FF.
  - Response: every element 03 (exact 0x2FA03); ovf=1. Identity A (01 on the diagonal) times the same B gives mat_out=B and ovf=0.
- Backpressure:
  - Stimulus: basic job with out_ready=0 for 10 cycles after out_valid, in_valid held high throughout.
  - Response: mat_out and out_valid stable; in_ready=0; no second accept until one cycle after the out_ready handshake.
- Operand isolation:
  - Stimulus: change mat_in_a/b every cycle during CALC.
  - Response: result still equals the product of the latched operands. Partial mat_out shows C[0][0]=08 after 3 CALC cycles, remaining elements 0.
- Reset mid-operation:
  - Stimulus: assert rst at CALC step 13, and separately during DONE.
  - Response: next cycle state=IDLE, in_ready=1, out_valid=0, busy=0, mat_out=0, ovf=0. A following basic job gives the correct result.
- Back-to-back:
  - Stimulus: two jobs with in_valid and out_ready tied high.
  - Response: second accept 29 cycles after the first; both results correct.
